data_bus_if: RTL

DATA_BUS_IF -- requirements
Module: data_bus_if

---
 rtl/data_bus_if_pkg.sv | 22 ++
 rtl/data_bus_if.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_bus_if_pkg.sv
// Shared bus widths, FSM state encoding and timeout defaults for the
// memory-stage bus interface.
package data_bus_if_pkg;

    localparam int DataBus     = 32;
    localparam int DataAddrBus = 32;
    localparam int SelBus      = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // The timeout counter is never narrower than 8 bits, wider if TIMEOUT needs it.
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/data_bus_if.sv
// Memory-stage to bus bridge: one outstanding word request, pipeline stall
// handshake, flush-discard of in-flight transactions and request timeout.
//
// state | meaning
// IDLE  | no transaction; a new access is accepted here
// REQ   | bus request outstanding, fields held stable until ack or timeout
// DONE  | completed; read buffer presented, waits for the pipeline to advance
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   mem_ce_i,
    input  logic                   mem_we_i,
    input  logic [SelBus-1:0]      mem_sel_i,
    input  logic [DataAddrBus-1:0] mem_addr_i,
    input  logic [DataBus-1:0]     mem_data_i,
    output logic [DataBus-1:0]     mem_rdata_o,

    output logic                   stallreq_o,
    input  logic                   stall_i,
    input  logic                   flush_i,

    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [SelBus-1:0]      bus_sel_o,
    output logic [DataAddrBus-1:0] bus_addr_o,
    output logic [DataBus-1:0]     bus_wdata_o,
    input  logic                   bus_ack_i,
    input  logic [DataBus-1:0]     bus_rdata_i,
    output logic                   bus_err_o
);

    localparam int unsigned CntW = tmo_cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [DataAddrBus-1:0] WordMask = {{(DataAddrBus-2){1'b1}}, 2'b00};

    logic [1:0]             state_q,   state_d;
    logic                   we_q,      we_d;
    logic [SelBus-1:0]      sel_q,     sel_d;
    logic [DataAddrBus-1:0] addr_q,    addr_d;
    logic [DataBus-1:0]     wdata_q,   wdata_d;
    logic [DataBus-1:0]     rbuf_q,    rbuf_d;
    logic [CntW-1:0]        cnt_q,     cnt_d;
    logic                   discard_q, discard_d;
    logic                   err_q,     err_d;
    logic                   discard_now;

    // A flush arriving in the completing cycle discards just like an earlier one.
    assign discard_now = discard_q | flush_i;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_ce_i && !flush_i) begin
                    state_d   = ST_REQ;
                    we_d      = mem_we_i;
                    sel_d     = mem_sel_i;
                    addr_d    = mem_addr_i & WordMask;
                    wdata_d   = mem_data_i;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus_ack_i) begin
                    if (!discard_now && !we_q) begin
                        rbuf_d = bus_rdata_i;
                    end
                    state_d   = discard_now ? ST_IDLE : ST_DONE;
                    discard_d = 1'b0;
                end else if (cnt_q == CntLast) begin
                    err_d = 1'b1;
                    if (!discard_now) begin
                        rbuf_d = '0;
                    end
                    state_d   = discard_now ? ST_IDLE : ST_DONE;
                    discard_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (flush_i) begin
                        discard_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (flush_i || !stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            err_q     <= err_d;
        end
    end

    // Reset gating keeps the combinational stall quiet while reset is held.
    assign stallreq_o  = rst & (((state_q == ST_IDLE) & mem_ce_i & ~flush_i) |
                                ((state_q == ST_REQ) & ~discard_q));
    assign bus_req_o   = (state_q == ST_REQ);
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_err_o   = err_q;
    assign mem_rdata_o = rbuf_q;

endmodule
